// File: rtl/carus_clk_gate_ctrl_pkg.sv
// Shared types and defaults for the Carus clock-enable controller.
// States, parameter defaults and the wake counter width used by the controller.
package carus_cg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

    localparam int DEF_IDLE_CNT_W  = 8;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_STAT_W      = 32;
    localparam int WAKE_CNT_W      = 4;

endpackage

// File: rtl/carus_clk_gate_ctrl_if.sv
// System-bus request handshake into Carus.
// The bus side holds req_i until req_ready_o is seen high.
interface carus_clk_gate_ctrl_if;
    import carus_cg_pkg::*;

    logic req_i;
    logic req_ready_o;

    modport master (output req_i, input req_ready_o);
    modport slave  (input req_i, output req_ready_o);

endinterface

// File: rtl/carus_clk_gate_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module carus_cg_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/carus_clk_gate_ctrl.sv
// Clock-enable controller for Carus: gates the accelerator clock after a
// programmable idle period and stalls bus requests until it is running again.
module carus_clk_gate_ctrl
    import carus_cg_pkg::*;
#(
    parameter int IDLE_CNT_W  = DEF_IDLE_CNT_W,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int STAT_W      = DEF_STAT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thr_i,
    input  logic                  busy_i,
    input  logic                  stat_clr_i,
    carus_clk_gate_ctrl_if.slave  bus,
    output logic                  clk_en_o,
    output logic                  gated_o,
    output logic [STAT_W-1:0]     gated_cycles_o
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

    if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 15)) begin : g_bad_wake_cycles
        $error("carus_clk_gate_ctrl: WAKE_CYCLES must be in 1..15");
    end

    cg_state_e             state_q, state_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  clk_en_q;
    logic                  wake_evt;

    // A disabled controller counts as a wake source so the clock is forced on.
    assign wake_evt = bus.req_i | busy_i | ~cfg_en_i;

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = '0;
        case (state_q)
            RUN: begin
                if (cfg_en_i && !busy_i && !bus.req_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (wake_evt) begin
                    state_d = RUN;
                end else if (idle_cnt >= cfg_idle_thr_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                if (wake_evt) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // The enable is registered from next-state so it changes on the same edge as the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= (state_d != GATED);
        end
    end

    carus_cg_sat_cnt #(.W(IDLE_CNT_W)) u_idle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i ((state_q != IDLE) || (state_d != IDLE)),
        .inc_i (1'b1),
        .cnt_o (idle_cnt)
    );

    carus_cg_sat_cnt #(.W(STAT_W)) u_stat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (stat_clr_i),
        .inc_i (state_q == GATED),
        .cnt_o (gated_cycles_o)
    );

    assign bus.req_ready_o = (state_q == RUN) || (state_q == IDLE);
    assign clk_en_o        = clk_en_q;
    assign gated_o         = (state_q == GATED);

endmodule
